// File: rtl/signed_operand_encoder.sv
// Keypad operand builder: turns single-cycle key events into a signed two-digit
// decimal operand (sign code, BCD digits, 8-bit two's-complement value).
module signed_operand_encoder (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic [3:0] sign,
    output logic [3:0] dig_tens,
    output logic [3:0] dig_ones,
    output logic [7:0] value,
    output logic       locked,
    output logic       done
);

    typedef enum logic [1:0] {EMPTY, ENTRY, LOCKED} state_t;

    localparam logic [3:0] KEY_MINUS = 4'hA;
    localparam logic [3:0] KEY_BACK  = 4'hB;
    localparam logic [3:0] KEY_CLEAR = 4'hC;
    localparam logic [3:0] KEY_ENTER = 4'hD;

    state_t             state, state_nxt;
    logic               neg, neg_nxt;
    logic [1:0]         count, count_nxt;
    logic [3:0]         tens, tens_nxt;
    logic [3:0]         ones, ones_nxt;
    logic signed [7:0]  value_r, value_nxt;
    logic               done_r, done_nxt;
    logic [6:0]         mag;
    logic               is_digit;
    logic               neg_norm;

    function automatic logic signed [7:0] to_twos(input logic is_neg, input logic [6:0] m);
        logic signed [7:0] ext;
        ext = signed'({1'b0, m});
        return is_neg ? -ext : ext;
    endfunction

    assign mag      = ({3'b000, tens} * 7'd10) + {3'b000, ones};
    assign is_digit = (key_code <= 4'd9);
    // A zero magnitude never carries a minus sign.
    assign neg_norm = neg && (mag != 7'd0);

    always_comb begin
        state_nxt = state;
        neg_nxt   = neg;
        count_nxt = count;
        tens_nxt  = tens;
        ones_nxt  = ones;
        value_nxt = value_r;
        done_nxt  = 1'b0;
        if (key_valid) begin
            if (key_code == KEY_CLEAR) begin
                state_nxt = EMPTY;
                neg_nxt   = 1'b0;
                count_nxt = 2'd0;
                tens_nxt  = 4'd0;
                ones_nxt  = 4'd0;
                value_nxt = 8'sd0;
            end else begin
                case (state)
                    EMPTY: begin
                        if (is_digit) begin
                            ones_nxt  = key_code;
                            count_nxt = 2'd1;
                            state_nxt = ENTRY;
                        end else if (key_code == KEY_MINUS) begin
                            neg_nxt = ~neg;
                        end
                    end
                    ENTRY: begin
                        if (is_digit) begin
                            if (count == 2'd1) begin
                                tens_nxt  = ones;
                                ones_nxt  = key_code;
                                count_nxt = 2'd2;
                            end
                        end else if (key_code == KEY_MINUS) begin
                            neg_nxt = ~neg;
                        end else if (key_code == KEY_BACK) begin
                            if (count == 2'd2) begin
                                ones_nxt  = tens;
                                tens_nxt  = 4'd0;
                                count_nxt = 2'd1;
                            end else begin
                                ones_nxt  = 4'd0;
                                count_nxt = 2'd0;
                                state_nxt = EMPTY;
                            end
                        end else if (key_code == KEY_ENTER) begin
                            neg_nxt   = neg_norm;
                            value_nxt = to_twos(neg_norm, mag);
                            done_nxt  = 1'b1;
                            state_nxt = LOCKED;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Stage boundary: all state and outputs registered
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= EMPTY;
            neg     <= 1'b0;
            count   <= 2'd0;
            tens    <= 4'd0;
            ones    <= 4'd0;
            value_r <= 8'sd0;
            done_r  <= 1'b0;
        end else begin
            state   <= state_nxt;
            neg     <= neg_nxt;
            count   <= count_nxt;
            tens    <= tens_nxt;
            ones    <= ones_nxt;
            value_r <= value_nxt;
            done_r  <= done_nxt;
        end
    end

    assign sign     = {3'b000, neg};
    assign dig_tens = tens;
    assign dig_ones = ones;
    assign value    = value_r;
    assign locked   = (state == LOCKED);
    assign done     = done_r;

endmodule
